// File: rtl/tff_arb_pkg.sv
// rtl/tff_arb_pkg.sv - shared state encoding and default sizes for the TFF bank arbiter
package tff_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single toggle flip-flop of the shared bank
module tff_cell (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (enable) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_bank_arbiter.sv
// rtl/tff_bank_arbiter.sv - arbitrates N_REQ requesters onto a shared TFF bank with 4-phase handshake
// TFF_ARB_FIXED_PRI_EN selects fixed lowest-index priority instead of round-robin.
module tff_bank_arbiter
  import tff_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     mask,
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [WIDTH-1:0]           tff_en,
  output logic [WIDTH-1:0]           q
);

  localparam int GW = $clog2(N_REQ);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] mask_lat;
  logic [WIDTH-1:0] sel_mask;
  logic [GW-1:0]    winner;
  logic             grant_load;

`ifdef TFF_ARB_FIXED_PRI_EN
  // Descending scan so the lowest asserted index is the last to be written.
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = GW'(i);
      end
    end
  end
`else
  logic [GW-1:0] rr_ptr;
  logic [GW:0]   rr_sum;
  logic [GW-1:0] rr_idx;
  logic          found;

  // Walk requesters starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_sum = '0;
    rr_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(N_REQ)) begin
        rr_sum = rr_sum - (GW+1)'(N_REQ);
      end
      rr_idx = rr_sum[GW-1:0];
      if (!found && req[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_load) begin
      rr_ptr <= (winner == GW'(N_REQ - 1)) ? '0 : winner + GW'(1);
    end
  end
`endif

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == GW'(i)) begin
        sel_mask = mask[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_id <= '0;
      mask_lat <= '0;
    end else begin
      state_q <= state_d;
      if (grant_load) begin
        grant_id <= winner;
        mask_lat <= sel_mask;
      end
    end
  end

  // Requests are only looked at in IDLE; changes during APPLY/ACK are ignored.
  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    ack        = '0;
    tff_en     = '0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_load = 1'b1;
          state_d    = ST_APPLY;
        end
      end
      ST_APPLY: begin
        tff_en  = mask_lat;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        ack[grant_id] = 1'b1;
        if (!req[grant_id]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    tff_cell u_cell (
      .clock  (clock),
      .reset  (reset),
      .enable (tff_en[g]),
      .q      (q[g])
    );
  end

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// tb/tb_tff_bank_arbiter.sv - randomized self-checking bench against a transaction-level model
module tb_tff_bank_arbiter;

  localparam int NR = 4;
  localparam int W  = 4;
  localparam int GW = $clog2(NR);

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   mask;
  logic [NR-1:0]     ack;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic [W-1:0]      tff_en;
  logic [W-1:0]      q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] q_m;
  int           rr_m;
  int           w;
  int           order[$];
  int           exp_order[5];
  logic [W-1:0] q_save;
  logic [NR-1:0] r;

  tff_bank_arbiter #(.N_REQ(NR), .WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .tff_en   (tff_en),
    .q        (q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] rq, input int rr);
`ifdef TFF_ARB_FIXED_PRI_EN
    for (int i = 0; i < NR; i++) if (rq[i]) return i;
`else
    for (int k = 0; k < NR; k++) if (rq[(rr + k) % NR]) return (rr + k) % NR;
`endif
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) begin
      req  = NR'($urandom);
      mask = (NR*W)'($urandom);
      @(negedge clock);
      check("rst_q", q, 0);
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_tff_en", tff_en, 0);
    end
    req   = '0;
    reset = 1'b1;
    q_m   = '0;
    rr_m  = 0;
  endtask

  task automatic grant_cycle(input logic [NR-1:0] rq, input logic [NR*W-1:0] m,
                             input int hold, input bit drop_early, output int win);
    logic [W-1:0]  mm;
    logic [NR-1:0] oh;
    logic [NR-1:0] noise;
    req  = rq;
    mask = m;
    win  = pick(rq, rr_m);
    mm   = m[win*W +: W];
    oh   = NR'(1) << win;
    @(posedge clock);
    @(negedge clock);
    check("apply_grant_id", grant_id, win);
    check("apply_tff_en", tff_en, mm);
    check("apply_busy", busy, 1);
    check("apply_ack", ack, 0);
    check("apply_q", q, q_m);
    rr_m = (win + 1) % NR;
    mask  = (NR*W)'($urandom);
    noise = NR'($urandom);
    req   = drop_early ? (noise & ~oh) : (noise | oh);
    @(posedge clock);
    @(negedge clock);
    q_m = q_m ^ mm;
    check("ack_on", ack, oh);
    check("ack_q", q, q_m);
    check("ack_tff_en", tff_en, 0);
    check("ack_busy", busy, 1);
    if (!drop_early) begin
      repeat (hold) begin
        req  = NR'($urandom) | oh;
        mask = (NR*W)'($urandom);
        @(posedge clock);
        @(negedge clock);
        check("ack_hold", ack, oh);
        check("ack_hold_q", q, q_m);
      end
      req = req & ~oh;
    end
    @(posedge clock);
    @(negedge clock);
    check("rel_ack", ack, 0);
    check("rel_busy", busy, 0);
    check("rel_q", q, q_m);
    check("rel_tff_en", tff_en, 0);
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    mask  = '0;
    do_reset();

    grant_cycle(4'b0001, {12'($urandom), 4'b1010}, 2, 1'b0, w);
    check("single_q", q, 4'b1010);

    req = '0;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check("idle_busy", busy, 0);
      check("idle_q", q, q_m);
    end

    q_save = q_m;
    grant_cycle(4'b0001, {12'($urandom), 4'b0110}, 1, 1'b0, w);
    grant_cycle(4'b0001, {12'($urandom), 4'b0110}, 0, 1'b0, w);
    check("double_q", q, q_save);
    grant_cycle(4'b0100, '0, 1, 1'b0, w);
    check("zero_mask_q", q, q_save);

    do_reset();
`ifdef TFF_ARB_FIXED_PRI_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    order.delete();
    repeat (5) begin
      grant_cycle('1, (NR*W)'($urandom), $urandom_range(0, 2), 1'b0, w);
      order.push_back(w);
    end
    for (int i = 0; i < 5; i++) check("rr_order", order[i], exp_order[i]);

    grant_cycle(4'b0010, (NR*W)'($urandom), 3, 1'b0, w);
    check("late_winner", w, 1);
    grant_cycle(4'b0100, (NR*W)'($urandom), 1, 1'b0, w);
    check("late_next", grant_id, 2);

    grant_cycle(4'b1000, (NR*W)'($urandom), 0, 1'b1, w);

    repeat (40) begin
      do r = NR'($urandom); while (r == '0);
      grant_cycle(r, (NR*W)'($urandom), $urandom_range(0, 3), 1'($urandom), w);
    end

    req  = 4'b0100;
    mask = (NR*W)'($urandom);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_q", q, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_tff_en", tff_en, 0);
    @(negedge clock);
    check("mid_rst_hold_q", q, 0);
    check("mid_rst_hold_ack", ack, 0);
    reset = 1'b1;
    q_m   = '0;
    rr_m  = 0;
    grant_cycle('1, (NR*W)'($urandom), 1, 1'b0, w);
    check("post_rst_winner", w, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
